// File: rtl/mtr_pwm_drv.sv
// Dual H-bridge PWM driver: signed wheel speed -> 2048-clk PWM pair with deadtime.
// Optional SLEW_LIMIT_EN: duty moves at most MAX_STEP per period.
module mtr_pwm_drv #(
  parameter int unsigned DEADTIME = 32
`ifdef SLEW_LIMIT_EN
  , parameter int unsigned MAX_STEP = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [10:0] lft_spd,
  input  logic signed [10:0] rght_spd,
  output logic               lftPWM1,
  output logic               lftPWM2,
  output logic               rghtPWM1,
  output logic               rghtPWM2,
  output logic               period_strt
);

  localparam logic [7:0]  DT       = 8'(DEADTIME);
  localparam logic [10:0] DUTY_RST = 11'h400;
`ifdef SLEW_LIMIT_EN
  localparam logic signed [11:0] STEP   = 12'(MAX_STEP);
  localparam logic [10:0]        STEP11 = 11'(MAX_STEP);
`endif

  logic [10:0]      cnt_q;
  logic             pstrt_q;
  logic [1:0][10:0] tgt;
  logic [1:0][10:0] duty_q, duty_d;
  logic [1:0]       raw_q, raw_d;
  logic [1:0][7:0]  dt_q, dt_d;
  logic [1:0]       p1_q, p1_d;
  logic [1:0]       p2_q, p2_d;
`ifdef SLEW_LIMIT_EN
  logic signed [1:0][11:0] diff;
`endif

  // Offset-binary: flipping the sign bit adds 1024.
  assign tgt[0] = {~lft_spd[10], lft_spd[9:0]};
  assign tgt[1] = {~rght_spd[10], rght_spd[9:0]};

  always_comb begin
    for (int s = 0; s < 2; s++) begin
`ifdef SLEW_LIMIT_EN
      diff[s] = $signed({1'b0, tgt[s]}) - $signed({1'b0, duty_q[s]});
`endif
      duty_d[s] = duty_q[s];
      if (cnt_q == 11'h7FF) begin
`ifdef SLEW_LIMIT_EN
        if (diff[s] > STEP)
          duty_d[s] = duty_q[s] + STEP11;
        else if (diff[s] < -STEP)
          duty_d[s] = duty_q[s] - STEP11;
        else
          duty_d[s] = tgt[s];
`else
        duty_d[s] = tgt[s];
`endif
      end
      raw_d[s] = (cnt_q < duty_q[s]);
      // Any edge, even mid-blank, restarts the full deadtime.
      if (raw_d[s] != raw_q[s])
        dt_d[s] = DT;
      else if (dt_q[s] != 8'd0)
        dt_d[s] = dt_q[s] - 8'd1;
      else
        dt_d[s] = dt_q[s];
      p1_d[s] = (dt_d[s] == 8'd0) &  raw_d[s];
      p2_d[s] = (dt_d[s] == 8'd0) & ~raw_d[s];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      pstrt_q <= 1'b0;
      duty_q  <= {2{DUTY_RST}};
      raw_q   <= '0;
      dt_q    <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
    end else begin
      cnt_q   <= cnt_q + 11'd1;
      pstrt_q <= (cnt_q == 11'h7FF);
      duty_q  <= duty_d;
      raw_q   <= raw_d;
      dt_q    <= dt_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
    end
  end

  assign lftPWM1     = p1_q[0];
  assign lftPWM2     = p2_q[0];
  assign rghtPWM1    = p1_q[1];
  assign rghtPWM2    = p2_q[1];
  assign period_strt = pstrt_q;

endmodule

// File: tb/tb_mtr_pwm_drv.sv
// Self-checking bench for mtr_pwm_drv: per-period high-time counts,
// overlap/deadtime monitor, reset and slew sequences.
module tb_mtr_pwm_drv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [10:0] lft_spd  = '0;
  logic signed [10:0] rght_spd = '0;
  logic lftPWM1, lftPWM2, rghtPWM1, rghtPWM2;
  logic period_strt;

  mtr_pwm_drv dut (
    .clk(clk),
    .rst(rst),
    .lft_spd(lft_spd),
    .rght_spd(rght_spd),
    .lftPWM1(lftPWM1),
    .lftPWM2(lftPWM2),
    .rghtPWM1(rghtPWM1),
    .rghtPWM2(rghtPWM2),
    .period_strt(period_strt)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Monitor: leg overlap and both-low gap length between leg highs.
  logic [1:0] a1, a2;
  assign a1 = {rghtPWM1, lftPWM1};
  assign a2 = {rghtPWM2, lftPWM2};
  int run [2];
  bit seen [2];
  bit gap_en = 1'b0;
  int gaps_n = 0;
  int gaps_bad = 0;
  int ovl = 0;

  always @(negedge clk) begin
    if (!rst) begin
      for (int s = 0; s < 2; s++) begin
        if (a1[s] && a2[s]) ovl++;
        if (!gap_en) begin
          run[s]  = 0;
          seen[s] = 1'b0;
        end else if (!a1[s] && !a2[s]) begin
          run[s]++;
        end else begin
          if (seen[s] && run[s] != 0) begin
            gaps_n++;
            if (run[s] != 32) gaps_bad++;
          end
          seen[s] = 1'b1;
          run[s]  = 0;
        end
      end
    end
  end

  // One window = samples at cnt 1..2047 then the next cnt 0.
  int m_l1, m_l2, m_r1, m_r2, m_ps;
  logic m_end_ps;

  task automatic measure(input int chg_at,
                         input logic signed [10:0] nl,
                         input logic signed [10:0] nr);
    m_l1 = 0; m_l2 = 0; m_r1 = 0; m_r2 = 0; m_ps = 0;
    for (int i = 0; i < 2048; i++) begin
      @(negedge clk);
      m_l1 += int'(lftPWM1);
      m_l2 += int'(lftPWM2);
      m_r1 += int'(rghtPWM1);
      m_r2 += int'(rghtPWM2);
      m_ps += int'(period_strt);
      if (i == chg_at) begin
        lft_spd  = nl;
        rght_spd = nr;
      end
    end
    m_end_ps = period_strt;
  endtask

  task automatic chk_meas(input string tag,
                          input int l1, input int l2,
                          input int r1, input int r2);
    chk({tag, "_l1"}, m_l1, l1);
    chk({tag, "_l2"}, m_l2, l2);
    chk({tag, "_r1"}, m_r1, r1);
    chk({tag, "_r2"}, m_r2, r2);
    chk({tag, "_pstrt"}, (m_ps == 1 && m_end_ps) ? 1 : 0, 1);
  endtask

  typedef struct {
    logic signed [10:0] l;
    logic signed [10:0] r;
    int l1, l2, r1, r2;
  } vec_t;

  vec_t vt [6];

`ifdef SLEW_LIMIT_EN
  localparam int NSTEP = 32;
`else
  localparam int NSTEP = 1;
`endif

  int exp_v;
  int rl, rr;

  initial begin
    vt[0] = '{11'sd0,     11'sd0,     992,  992, 992,  992};
    vt[1] = '{11'h400,    11'sd0,     0,   2048, 992,  992};
    vt[2] = '{11'sd256,  -11'sd256,   1248, 736, 736, 1248};
    vt[3] = '{-11'sd1004, 11'sd500,   0,   1996, 1492, 492};
    vt[4] = '{11'sd100,  -11'sd1000,  1092, 892, 0,   1992};
    vt[5] = '{11'sd1023, -11'sd1023,  2015, 0,   0,   2015};

    @(negedge clk);
    chk("reset_outs",
        int'({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, period_strt}), 0);
    rst = 1'b0;

    measure(1000, vt[0].l, vt[0].r);
    chk_meas("t1_reset_period", 992, 992, 992, 992);

`ifndef SLEW_LIMIT_EN
    for (int i = 0; i < 6; i++) begin
      if (i < 5) measure(1000, vt[i+1].l, vt[i+1].r);
      else       measure(1000, 11'sd0, 11'sd0);
      chk_meas($sformatf("vec%0d", i),
               vt[i].l1, vt[i].l2, vt[i].r1, vt[i].r2);
    end

    measure(499, 11'sd256, 11'sd0);
    chk("t4_mid_change_l1", m_l1, 992);
    chk("t4_mid_change_r1", m_r1, 992);
    measure(-1, 11'sd0, 11'sd0);
    chk("t4_next_l1", m_l1, 1248);
    chk("t4_next_r1", m_r1, 992);
`endif

    gap_en = 1'b1;
    for (int p = 0; p < 10; p++) begin
      rl = int'($urandom_range(1920, 0)) - 960;
      rr = int'($urandom_range(1920, 0)) - 960;
      measure(int'($urandom_range(2000, 0)), 11'(rl), 11'(rr));
    end
    gap_en = 1'b0;
    chk("t3_gaps_seen", (gaps_n > 0) ? 1 : 0, 1);
    chk("t3_gap_len", gaps_bad, 0);
    chk("overlap", ovl, 0);

    repeat (1000) @(negedge clk);
    #1 rst = 1'b1;
    #1 chk("t6_rst_async",
           int'({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, period_strt}), 0);
    lft_spd  = '0;
    rght_spd = '0;
    @(negedge clk);
    chk("t6_rst_hold",
        int'({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, period_strt}), 0);
    rst = 1'b0;
    measure(0, 11'sd512, 11'sd0);
    chk_meas("t6_post_rst", 992, 992, 992, 992);

    for (int k = 1; k <= NSTEP; k++) begin
      measure((k == NSTEP) ? 0 : -1, 11'sd0, 11'sd0);
`ifdef SLEW_LIMIT_EN
      exp_v = 1024 + 16 * k - 32;
`else
      exp_v = 1504;
`endif
      if (k == 1 || k == 2 || k == NSTEP)
        chk($sformatf("t5_up_k%0d", k), m_l1, exp_v);
    end
    measure(-1, 11'sd0, 11'sd0);
`ifdef SLEW_LIMIT_EN
    exp_v = 1488;
`else
    exp_v = 992;
`endif
    chk("t5_down_l1", m_l1, exp_v);
    chk("t5_right_l1", m_r1, 992);
    chk("overlap_final", ovl, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
